// File: rtl/digit_sprite_renderer_if.sv
// digit_sprite_renderer_if: sprite ROM address/data bus between the renderer and the digit ROM
interface digit_sprite_renderer_if;
  logic [4:0] rom_row;
  logic [4:0] rom_col;
  logic [11:0] rom_data;
  modport master (output rom_row, rom_col, input rom_data);
  modport slave (input rom_row, rom_col, output rom_data);
endinterface

// File: rtl/digit_sprite_renderer.sv
// digit_sprite_renderer: raster-to-sprite address generator with upscaling, frame-latched origin and keyed colour mix
module digit_sprite_renderer #(
  parameter int SCALE = 2,
  parameter int SPRITE_W = 25,
  parameter int SPRITE_H = 30,
  parameter int H_LAST = 639,
  parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
  input logic clk,
  input logic reset,
  input logic pixel_en,
  input logic video_on,
  input logic frame_start,
  input logic [9:0] x,
  input logic [9:0] y,
  input logic [9:0] pos_x,
  input logic [9:0] pos_y,
  input logic [11:0] bg_color,
  digit_sprite_renderer_if.master rom,
  output logic [11:0] rgb,
  output logic rgb_valid
);
  localparam logic [11:0] BW = 12'(SPRITE_W * SCALE);
  localparam logic [11:0] BH = 12'(SPRITE_H * SCALE);
  localparam logic [2:0] SL = 3'(SCALE - 1);
  logic [9:0] org_x_q, org_x_d, org_y_q, org_y_d;
  logic [2:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d, sx, sy;
  logic [4:0] col_q, col_d, row_q, row_d, cx, cy;
  logic [4:0] rom_row_q, rom_row_d, rom_col_q, rom_col_d;
  logic [1:0] box_q, box_d, von_q, von_d, pen_q, pen_d;
  logic [11:0] bg1_q, bg1_d, bg2_q, bg2_d, rgb_q, rgb_d;
  logic rgb_valid_q, rgb_valid_d, h_in, v_in, h_adv, v_adv;
  always_comb begin
    h_in = {2'b0, x} >= {2'b0, org_x_q} && {2'b0, x} < {2'b0, org_x_q} + BW;
    v_in = {2'b0, y} >= {2'b0, org_y_q} && {2'b0, y} < {2'b0, org_y_q} + BH;
    sx = x == org_x_q ? 3'd0 : sub_x_q;
    cx = x == org_x_q ? 5'd0 : col_q;
    sy = y == org_y_q ? 3'd0 : sub_y_q;
    cy = y == org_y_q ? 5'd0 : row_q;
    h_adv = pixel_en && h_in;
    v_adv = pixel_en && v_in && x == 10'(H_LAST);
    org_x_d = frame_start ? pos_x : org_x_q;
    org_y_d = frame_start ? pos_y : org_y_q;
    sub_x_d = h_adv ? (sx == SL ? 3'd0 : sx + 3'd1) : sub_x_q;
    col_d = h_adv ? (sx == SL ? cx + 5'd1 : cx) : col_q;
    sub_y_d = v_adv ? (sy == SL ? 3'd0 : sy + 3'd1) : sub_y_q;
    row_d = v_adv ? (sy == SL ? cy + 5'd1 : cy) : row_q;
    rom_row_d = h_adv && v_in ? cy : rom_row_q;
    rom_col_d = h_adv && v_in ? cx : rom_col_q;
    box_d = {box_q[0], h_in && v_in};
    von_d = {von_q[0], video_on};
    pen_d = {pen_q[0], pixel_en};
    bg1_d = bg_color;
    bg2_d = bg1_q;
    rgb_d = !von_q[1] ? 12'h000 : box_q[1] && rom.rom_data != TRANSPARENT ? rom.rom_data : bg2_q;
    rgb_valid_d = pen_q[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      org_x_q <= '0;
      org_y_q <= '0;
      sub_x_q <= '0;
      sub_y_q <= '0;
      col_q <= '0;
      row_q <= '0;
      rom_row_q <= '0;
      rom_col_q <= '0;
      box_q <= '0;
      von_q <= '0;
      pen_q <= '0;
      bg1_q <= '0;
      bg2_q <= '0;
      rgb_q <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      sub_x_q <= sub_x_d;
      sub_y_q <= sub_y_d;
      col_q <= col_d;
      row_q <= row_d;
      rom_row_q <= rom_row_d;
      rom_col_q <= rom_col_d;
      box_q <= box_d;
      von_q <= von_d;
      pen_q <= pen_d;
      bg1_q <= bg1_d;
      bg2_q <= bg2_d;
      rgb_q <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end
  assign rom.rom_row = rom_row_q;
  assign rom.rom_col = rom_col_q;
  assign rgb = rgb_q;
  assign rgb_valid = rgb_valid_q;
endmodule

// File: tb/tb_digit_sprite_renderer.sv
// tb_digit_sprite_renderer: directed checks of mapping, latency, keying, origin latch, stalls, reset and clipping
module tb_digit_sprite_renderer;
  logic clk = 1'b0, reset = 1'b1, pixel_en = 1'b0, video_on = 1'b0, frame_start = 1'b0;
  logic [9:0] x = '0, y = '0, pos_x = '0, pos_y = '0;
  logic [11:0] bg_color = '0, rgb, rgb2;
  logic rgb_valid, rgb_valid2;
  int passed = 0, fails = 0, total = 0;
  logic [11:0] h_rgb [2];
  logic h_val [2];
  logic h_chk [2];
  digit_sprite_renderer_if r1 ();
  digit_sprite_renderer_if r2 ();
  digit_sprite_renderer #(.SCALE(2)) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .video_on(video_on), .frame_start(frame_start),
    .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y), .bg_color(bg_color), .rom(r1),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );
  digit_sprite_renderer #(.SCALE(1)) dut1 (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .video_on(video_on), .frame_start(frame_start),
    .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y), .bg_color(bg_color), .rom(r2),
    .rgb(rgb2), .rgb_valid(rgb_valid2)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] rom_f(input logic [4:0] r, input logic [4:0] c);
    return c == 5'd0 ? 12'hFFF : {2'b00, r, c - 5'd1};
  endfunction
  function automatic logic [11:0] pix(input logic [4:0] r, input logic [4:0] c, input logic [11:0] bg);
    logic [11:0] d = rom_f(r, c);
    return d == 12'hFFF ? bg : d;
  endfunction
  always @(posedge clk) begin
    r1.rom_data <= rom_f(r1.rom_row, r1.rom_col);
    r2.rom_data <= rom_f(r2.rom_row, r2.rom_col);
  end
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic hist_clear();
    for (int i = 0; i < 2; i++) begin
      h_rgb[i] = '0;
      h_val[i] = 1'b0;
      h_chk[i] = 1'b1;
    end
  endtask
  task automatic step(input logic [9:0] xi, input logic [9:0] yi, input logic pen, input logic von,
                      input logic fs, input logic [11:0] bg, input logic ca, input logic [4:0] er,
                      input logic [4:0] ec, input logic cr, input logic [11:0] ergb);
    x = xi;
    y = yi;
    pixel_en = pen;
    video_on = von;
    frame_start = fs;
    bg_color = bg;
    @(posedge clk);
    #1;
    if (ca) begin
      chk($sformatf("rom_row@%0d,%0d", xi, yi), 12'(r1.rom_row), 12'(er));
      chk($sformatf("rom_col@%0d,%0d", xi, yi), 12'(r1.rom_col), 12'(ec));
    end
    chk($sformatf("rgb_valid@%0d,%0d", xi, yi), 12'(rgb_valid), 12'(h_val[1]));
    if (h_chk[1]) chk($sformatf("rgb@%0d,%0d", xi, yi), rgb, h_rgb[1]);
    h_rgb[1] = h_rgb[0];
    h_val[1] = h_val[0];
    h_chk[1] = h_chk[0];
    h_rgb[0] = ergb;
    h_val[0] = pen;
    h_chk[0] = cr;
    frame_start = 1'b0;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_rgb"}, rgb, 12'h000);
    chk({tag, "_rgb_valid"}, 12'(rgb_valid), 12'h000);
    chk({tag, "_rom_row"}, 12'(r1.rom_row), 12'h000);
    chk({tag, "_rom_col"}, 12'(r1.rom_col), 12'h000);
  endtask
  initial begin
    hist_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    reset = 1'b0;
    pos_x = 10'd100;
    pos_y = 10'd50;
    step(0, 0, 1, 1, 0, 12'h00F, 1, 0, 0, 1, pix(0, 0, 12'h00F));
    step(1, 0, 1, 1, 0, 12'h00F, 1, 0, 0, 1, pix(0, 0, 12'h00F));
    step(2, 0, 1, 1, 0, 12'h00F, 1, 0, 1, 1, pix(0, 1, 12'h00F));
    step(3, 0, 1, 1, 1, 12'h00F, 1, 0, 1, 1, pix(0, 1, 12'h00F));
    pos_x = 10'd300;
    pos_y = 10'd200;
    step(99, 50, 1, 1, 0, 12'h123, 1, 0, 1, 1, 12'h123);
    for (int xi = 100; xi < 150; xi++) begin
      step(10'(xi), 50, 1, 1, 0, 12'h00F, 1, 0, 5'((xi - 100) / 2), 1, pix(0, 5'((xi - 100) / 2), 12'h00F));
      if (xi == 103) repeat (3) step(103, 50, 0, 1, 0, 12'h00F, 1, 0, 1, 0, 12'h000);
    end
    step(150, 50, 1, 1, 0, 12'h123, 1, 0, 24, 1, 12'h123);
    step(639, 50, 1, 1, 0, 12'h123, 1, 0, 24, 1, 12'h123);
    for (int yi = 51; yi < 110; yi++) begin
      step(100, 10'(yi), 1, 1, 0, 12'h00F, 1, 5'((yi - 50) / 2), 0, 1, pix(5'((yi - 50) / 2), 0, 12'h00F));
      if (yi == 109) begin
        step(101, 109, 1, 1, 0, 12'h00F, 1, 29, 0, 1, pix(29, 0, 12'h00F));
        step(102, 109, 1, 1, 0, 12'h00F, 1, 29, 1, 1, pix(29, 1, 12'h00F));
        step(103, 109, 1, 0, 0, 12'h00F, 1, 29, 1, 1, 12'h000);
      end
      step(639, 10'(yi), 1, 1, 0, 12'h123, 1, 5'((yi - 50) / 2), yi == 109 ? 5'd1 : 5'd0, 1, 12'h123);
    end
    step(100, 110, 1, 1, 0, 12'h123, 1, 29, 1, 1, 12'h123);
    step(0, 0, 0, 0, 1, 12'h000, 1, 29, 1, 0, 12'h000);
    step(100, 50, 1, 1, 0, 12'h123, 1, 29, 1, 1, 12'h123);
    step(300, 200, 1, 1, 0, 12'h00F, 1, 0, 0, 1, pix(0, 0, 12'h00F));
    step(301, 200, 1, 1, 0, 12'h00F, 1, 0, 0, 1, pix(0, 0, 12'h00F));
    step(302, 200, 1, 1, 0, 12'h00F, 1, 0, 1, 1, pix(0, 1, 12'h00F));
    reset = 1'b1;
    x = 10'd303;
    repeat (2) begin
      @(posedge clk);
      #1;
      reset_checks("midreset");
    end
    reset = 1'b0;
    hist_clear();
    step(0, 0, 1, 1, 0, 12'h00F, 1, 0, 0, 1, pix(0, 0, 12'h00F));
    step(1, 0, 1, 1, 0, 12'h00F, 1, 0, 0, 1, pix(0, 0, 12'h00F));
    step(2, 0, 1, 1, 0, 12'h00F, 1, 0, 1, 1, pix(0, 1, 12'h00F));
    pos_x = 10'd639;
    pos_y = 10'd10;
    step(0, 0, 0, 0, 1, 12'h000, 1, 0, 1, 0, 12'h000);
    for (int yi = 10; yi < 13; yi++) begin
      step(639, 10'(yi), 1, 1, 0, 12'h00F, 1, 5'((yi - 10) / 2), 0, 1, pix(5'((yi - 10) / 2), 0, 12'h00F));
      chk($sformatf("s1_rom_row@639,%0d", yi), 12'(r2.rom_row), 12'(yi - 10));
      chk($sformatf("s1_rom_col@639,%0d", yi), 12'(r2.rom_col), 12'h000);
    end
    pos_x = 10'd630;
    pos_y = 10'd470;
    step(0, 0, 0, 0, 1, 12'h000, 1, 1, 0, 0, 12'h000);
    for (int yi = 470; yi < 480; yi++) begin
      step(629, 10'(yi), 1, 1, 0, 12'h123, 0, 0, 0, 1, 12'h123);
      if (yi > 470) begin
        chk($sformatf("s1_hold_row@629,%0d", yi), 12'(r2.rom_row), 12'(yi - 471));
        chk($sformatf("s1_hold_col@629,%0d", yi), 12'(r2.rom_col), 12'd9);
      end
      for (int xi = 630; xi < 640; xi++) begin
        step(10'(xi), 10'(yi), 1, 1, 0, 12'h123, 1, 5'((yi - 470) / 2), 5'((xi - 630) / 2), 1,
             pix(5'((yi - 470) / 2), 5'((xi - 630) / 2), 12'h123));
        chk($sformatf("s1_rom_row@%0d,%0d", xi, yi), 12'(r2.rom_row), 12'(yi - 470));
        chk($sformatf("s1_rom_col@%0d,%0d", xi, yi), 12'(r2.rom_col), 12'(xi - 630));
      end
      chk($sformatf("s1_rgb@637,%0d", yi), rgb2, pix(5'(yi - 470), 7, 12'h123));
      chk($sformatf("s1_rgb_valid@637,%0d", yi), 12'(rgb_valid2), 12'h001);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/digit_sprite_renderer.md
# digit_sprite_renderer

Pixel-address generator and colour mixer that sits directly upstream of the 25x30 digit sprite ROMs and downstream of the VGA sync counter. It maps the raster position to a sprite row/column, with integer upscaling and a frame-latched on-screen origin. It drives the ROM address and consumes the ROM's registered 12-bit colour. It outputs the final pixel colour, with transparency keying against a background colour.

## Interface
- SCALE, 2: integer upscale factor, 1..8; each sprite texel covers SCALE x SCALE screen pixels.
- SPRITE_W, 25: sprite width in texels.
- SPRITE_H, 30: sprite height in texels.
- H_LAST, 639: last visible x of a line; the row counter advances here.
- TRANSPARENT, 12'hFFF: ROM colour replaced by bg_color.
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- pixel_en  in  1  x/y carry a new pixel this cycle.
- video_on  in  1  visible-area flag from the sync counter.
- frame_start  in  1  one-cycle pulse, once per frame, outside the visible area.
- x  in  10  current pixel column.
- y  in  10  current pixel line.
- pos_x  in  10  requested sprite origin x.
- pos_y  in  10  requested sprite origin y.
- bg_color  in  12  background colour for this pixel.
- rom_row  out  5  sprite ROM row address, registered.
- rom_col  out  5  sprite ROM column address, registered.
- rom_data  in  12  sprite ROM colour, valid one cycle after rom_row/rom_col.
- rgb  out  12  final pixel colour, registered.
- rgb_valid  out  1  rgb corresponds to a pixel_en pixel.

## Operation
- **Origin latch.** org_x/org_y load pos_x/pos_y on frame_start.
  - A pixel presented in the same cycle as frame_start uses the old origin.
  - pos_x/pos_y changes at any other time are ignored.
- **Box test.** Uses 12-bit arithmetic so there is no wrap.
  - h_in = org_x <= x < org_x + SPRITE_W*SCALE.
  - v_in = org_y <= y < org_y + SPRITE_H*SCALE.
  - Parts of the box past x=639 or y=479 simply never occur.
- **Horizontal counters.** sub_x (0..SCALE-1) and col_cnt (0..24), no divider.
  - On a pixel_en cycle, the effective values are 0/0 if x == org_x, else the stored values.
  - If h_in, the next state is: sub_x+1, or 0 with col_cnt+1 when sub_x == SCALE-1.
- **Vertical counters.** sub_y and row_cnt follow the same scheme, keyed on y == org_y.
  - They advance only on pixel_en with x == H_LAST and v_in.
- **Required result.** rom_col = (x-org_x)/SCALE and rom_row = (y-org_y)/SCALE, exactly, for raster-ordered input.
- **ROM address.** rom_row/rom_col load the effective counters on pixel_en with h_in && v_in. Otherwise they hold.
- **Pipeline.** Flags in_box = h_in && v_in, video_on, pixel_en, and bg_color are delayed two stages to align with rom_data.
- **Mixer.** Registered; first matching rule wins:
  1. video_on_d2 = 0 -> rgb = 0.
  2. in_box_d2 && rom_data != TRANSPARENT -> rgb = rom_data.
  3. Otherwise -> rgb = bg_color_d2.
  - rgb_valid = pixel_en_d2.
- **Stalls.** pixel_en = 0 freezes all counters and the ROM address. The pipeline still shifts every clock.

## Timing
- Inputs are sampled at edge N.
  - rom_row/rom_col are valid after edge N.
  - rom_data is valid after edge N+1.
  - rgb/rgb_valid are valid after edge N+2.
  - Latency is fixed; there is no backpressure.
- **Reset values.** rom_row=0, rom_col=0, rgb=0, rgb_valid=0. org_x=org_y=0, all counters 0, all pipeline flags 0.
- **Reset mid-frame.** All state is cleared at the next edge.
  - The origin stays (0,0) until the next frame_start.
  - rgb_valid stays 0 for two cycles after reset deasserts.
- **x == org_x and x == H_LAST in one cycle.** The horizontal reload and the vertical advance both apply.
- **SCALE = 1.** sub_x/sub_y stay 0; the counters advance on every in-box pixel or line.

## Test plan
- **Reset.** Hold reset 2 cycles mid-stream -> rgb=0, rgb_valid=0, rom_row=rom_col=0. After release, pixels at origin (0,0) map from row/col 0.
- **Scaled mapping.** SCALE=2, pos=(100,50), frame_start, full raster. Expected rom (row,col):
  - (100,50) -> (0,0); (101,50) -> (0,0); (102,50) -> (0,1); (149,50) -> (0,24).
  - (150,50) -> outside, rgb=bg.
  - y=52 -> row 1; y=109 -> row 29; y=110 -> outside.
- **Latency and keying.** ROM model returns 12'hFFF, then 12'h000; bg_color=12'h00F. Expected:
  - rgb=12'h00F, then 12'h000.
  - Each rgb appears exactly at edge N+2; rgb_valid is high for those pixels.
- **Origin latch.** Mid-frame, change pos to (300,200) without frame_start -> the sprite still draws at (100,50). After frame_start it draws at (300,200), and (100,50) gives bg.
- **Blanking and stalls.** Hold video_on=0 inside the box -> rgb=0. Insert 3 pixel_en=0 cycles between x=103 and x=104 -> rom_col holds 1, rgb_valid drops for 3 cycles, and x=104 still maps to col 2.
- **Edge clipping.** pos=(630,470), SCALE=1 -> cols 0..9 are drawn on lines 470..479. Row 0 at y=470, with no wrap into x<630.
